lycalo_trig_shaper: RTL and testbench

Downstream stage of the LYCALO calorimeter block. Consumes its registered charge-sum trigger, OR trigger and signed charge sum, and turns a selected trigger source into a single prescaled, dead-time-protected trigger pulse. For each accepted trigger it reports the peak charge sum seen over a programmable gate window. It also keeps raw and accepted trigger counters for slow-control readout.

---
 rtl/lycalo_trig_shaper.sv | 186 ++++++++++++++++++
 tb/tb_lycalo_trig_shaper.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lycalo_trig_shaper.sv
// Trigger shaper: selects a LYCALO trigger source, prescales its rising edges, and emits one dead-time-protected pulse per accepted edge.
// Latency: TRGOUT one cycle after the accepted edge. PEAKVALID/TRGPEAK G cycles after it, where G = max(GATELEN,1).
// Backpressure: none. Edges that arrive during the gate window or the holdoff are counted in RAWCOUNT and then dropped.
//
// Ports: CLK/RST (sync, active-high); ENABLE, CNTCLR control inputs; LYCALOTRG/LYCALOORTRG/LYCALOQSUM from the
// LYCALO block; SRCSEL, PRESCALE, GATELEN, HOLDOFF configuration; TRGOUT, BUSY, TRGPEAK, PEAKVALID,
// RAWCOUNT, TRGCOUNT registered outputs.
module lycalo_trig_shaper #(
    parameter int QW = 20,
    parameter int CW = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic                 CNTCLR,
    input  logic                 LYCALOTRG,
    input  logic                 LYCALOORTRG,
    input  logic signed [QW-1:0] LYCALOQSUM,
    input  logic [1:0]           SRCSEL,
    input  logic [15:0]          PRESCALE,
    input  logic [7:0]           GATELEN,
    input  logic [15:0]          HOLDOFF,
    output logic                 TRGOUT,
    output logic                 BUSY,
    output logic signed [QW-1:0] TRGPEAK,
    output logic                 PEAKVALID,
    output logic [CW-1:0]        RAWCOUNT,
    output logic [CW-1:0]        TRGCOUNT
);

    typedef enum logic [1:0] {ST_IDLE, ST_GATE, ST_HOLD} state_t;

    state_t               state_q, state_d;
    logic                 sd_q;
    logic [15:0]          pcnt_q, pcnt_d;
    logic [7:0]           gcnt_q, gcnt_d;
    logic [15:0]          hcnt_q, hcnt_d;
    logic signed [QW-1:0] peak_q, peak_d;
    logic signed [QW-1:0] trgpeak_q, trgpeak_d;
    logic                 trgout_q, trgout_d;
    logic                 pv_q, pv_d;
    logic                 busy_q, busy_d;
    logic [CW-1:0]        raw_q, raw_d;
    logic [CW-1:0]        trg_q, trg_d;

    logic                 src;
    logic                 src_edge;
    logic                 cand;
    logic                 accept;
    logic [7:0]           glen;
    logic signed [QW-1:0] qmax;

    always_comb begin
        case (SRCSEL)
            2'd0:    src = LYCALOTRG;
            2'd1:    src = LYCALOORTRG;
            2'd2:    src = LYCALOTRG & LYCALOORTRG;
            default: src = LYCALOTRG | LYCALOORTRG;
        endcase
    end

    assign src_edge = src & ~sd_q;
    assign cand     = src_edge & ENABLE;
    assign glen     = (GATELEN == 8'd0) ? 8'd1 : GATELEN;
    // Signed running maximum including the current sample; this compare is the critical path.
    assign qmax     = (LYCALOQSUM > peak_q) ? LYCALOQSUM : peak_q;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        gcnt_d    = gcnt_q;
        hcnt_d    = hcnt_q;
        peak_d    = peak_q;
        trgpeak_d = trgpeak_q;
        trgout_d  = 1'b0;
        pv_d      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cand) begin
                    if (pcnt_q >= PRESCALE) begin
                        accept = 1'b1;
                        pcnt_d = 16'd0;
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
                if (accept) begin
                    trgout_d = 1'b1;
                    if (glen == 8'd1) begin
                        // A one-sample window closes in the same cycle that it opens.
                        trgpeak_d = LYCALOQSUM;
                        pv_d      = 1'b1;
                        if (HOLDOFF != 16'd0) begin
                            state_d = ST_HOLD;
                            hcnt_d  = HOLDOFF;
                        end
                    end else begin
                        state_d = ST_GATE;
                        peak_d  = LYCALOQSUM;
                        gcnt_d  = glen - 8'd1;   // samples still to take after this one
                    end
                end
            end
            ST_GATE: begin
                peak_d = qmax;
                if (gcnt_q == 8'd1) begin
                    trgpeak_d = qmax;
                    pv_d      = 1'b1;
                    if (HOLDOFF != 16'd0) begin
                        state_d = ST_HOLD;
                        hcnt_d  = HOLDOFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (hcnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        // A clear has priority over a count in the same cycle. Both counters saturate.
        if (CNTCLR)
            raw_d = '0;
        else if (cand && (raw_q != '1))
            raw_d = raw_q + CW'(1);
        else
            raw_d = raw_q;

        if (CNTCLR)
            trg_d = '0;
        else if (accept && (trg_q != '1))
            trg_d = trg_q + CW'(1);
        else
            trg_d = trg_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sd_q      <= 1'b1;     // a source already high at reset release is not an edge
            pcnt_q    <= '0;
            gcnt_q    <= '0;
            hcnt_q    <= '0;
            peak_q    <= '0;
            trgpeak_q <= '0;
            trgout_q  <= 1'b0;
            pv_q      <= 1'b0;
            busy_q    <= 1'b0;
            raw_q     <= '0;
            trg_q     <= '0;
        end else begin
            state_q   <= state_d;
            sd_q      <= src;
            pcnt_q    <= pcnt_d;
            gcnt_q    <= gcnt_d;
            hcnt_q    <= hcnt_d;
            peak_q    <= peak_d;
            trgpeak_q <= trgpeak_d;
            trgout_q  <= trgout_d;
            pv_q      <= pv_d;
            busy_q    <= busy_d;
            raw_q     <= raw_d;
            trg_q     <= trg_d;
        end
    end

    assign TRGOUT    = trgout_q;
    assign BUSY      = busy_q;
    assign TRGPEAK   = trgpeak_q;
    assign PEAKVALID = pv_q;
    assign RAWCOUNT  = raw_q;
    assign TRGCOUNT  = trg_q;

endmodule

// File: tb/tb_lycalo_trig_shaper.sv
// Testbench for lycalo_trig_shaper: directed table and sequences, then randomized stimulus checked against an event-level model.
// A second instance with 3-bit counters shares all inputs, so counter saturation can be reached quickly.
module tb_lycalo_trig_shaper;
    localparam int QW = 20;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RST, ENABLE, CNTCLR, LYCALOTRG, LYCALOORTRG;
    logic signed [QW-1:0] LYCALOQSUM;
    logic [1:0]           SRCSEL;
    logic [15:0]          PRESCALE;
    logic [7:0]           GATELEN;
    logic [15:0]          HOLDOFF;

    logic                 TRGOUT, BUSY, PEAKVALID;
    logic signed [QW-1:0] TRGPEAK;
    logic [31:0]          RAWCOUNT, TRGCOUNT;
    logic                 s_trgout, s_busy, s_pv;
    logic signed [QW-1:0] s_trgpeak;
    logic [2:0]           s_raw, s_trg;

    lycalo_trig_shaper #(.QW(QW), .CW(32)) u_dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CNTCLR(CNTCLR),
        .LYCALOTRG(LYCALOTRG), .LYCALOORTRG(LYCALOORTRG), .LYCALOQSUM(LYCALOQSUM),
        .SRCSEL(SRCSEL), .PRESCALE(PRESCALE), .GATELEN(GATELEN), .HOLDOFF(HOLDOFF),
        .TRGOUT(TRGOUT), .BUSY(BUSY), .TRGPEAK(TRGPEAK), .PEAKVALID(PEAKVALID),
        .RAWCOUNT(RAWCOUNT), .TRGCOUNT(TRGCOUNT));

    lycalo_trig_shaper #(.QW(QW), .CW(3)) u_sat (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CNTCLR(CNTCLR),
        .LYCALOTRG(LYCALOTRG), .LYCALOORTRG(LYCALOORTRG), .LYCALOQSUM(LYCALOQSUM),
        .SRCSEL(SRCSEL), .PRESCALE(PRESCALE), .GATELEN(GATELEN), .HOLDOFF(HOLDOFF),
        .TRGOUT(s_trgout), .BUSY(s_busy), .TRGPEAK(s_trgpeak), .PEAKVALID(s_pv),
        .RAWCOUNT(s_raw), .TRGCOUNT(s_trg));

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs set after tick() belong to the current cycle. Outputs read after tick() belong to the next cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input int ps, input int gl, input int ho);
        SRCSEL = sel; PRESCALE = 16'(ps); GATELEN = 8'(gl); HOLDOFF = 16'(ho);
    endtask

    task automatic clr_counts();
        CNTCLR = 1'b1; tick(); CNTCLR = 1'b0;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       trg;
        logic       orr;
        logic       exp_trg;
    } vec_t;

    // Event-level reference model state.
    bit     m_sprev;
    int     m_pcnt, m_next_free, m_pv_at, m_win_start, m_h;
    longint m_raw, m_trg, m_sraw, m_strg, m_peak;
    int     hist[256];
    int     cyc;

    function automatic bit src_of(input logic [1:0] sel, input logic a, input logic b);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return a && b;
            default: return a || b;
        endcase
    endfunction

    initial begin
        vec_t   tbl[8];
        int     qs[4];
        int     cnt;
        bit     e_trgout, e_pv, e_busy, s, cand, acc;
        int     g;

        RST = 1'b1; ENABLE = 1'b1; CNTCLR = 1'b0; LYCALOTRG = 1'b0; LYCALOORTRG = 1'b0;
        LYCALOQSUM = '0; cfg(2'd0, 0, 1, 0);
        tick(); tick();
        check("rst_trgout", TRGOUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_pv", PEAKVALID, 0);
        check("rst_trgpeak", TRGPEAK, 0);
        check("rst_raw", RAWCOUNT, 0);
        check("rst_trgcnt", TRGCOUNT, 0);
        RST = 1'b0;

        // Source-select table: both inputs low for two cycles, then one cycle of the vector.
        tbl[0] = '{2'd0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{2'd0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{2'd1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{2'd1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{2'd2, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2'd2, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{2'd3, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{2'd3, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            SRCSEL = tbl[i].sel; LYCALOTRG = 1'b0; LYCALOORTRG = 1'b0;
            tick(); tick();
            LYCALOTRG = tbl[i].trg; LYCALOORTRG = tbl[i].orr;
            tick();
            check($sformatf("srcsel_tbl[%0d]", i), TRGOUT, tbl[i].exp_trg);
        end
        LYCALOTRG = 1'b0; LYCALOORTRG = 1'b0; tick();
        check("tbl_raw", RAWCOUNT, 5);
        check("tbl_trgcnt", TRGCOUNT, 5);

        // Basic accept: G=4, H=10.
        cfg(2'd0, 0, 4, 10); clr_counts();
        qs[0] = 5; qs[1] = -3; qs[2] = 40; qs[3] = 12;
        LYCALOTRG = 1'b1; LYCALOQSUM = QW'(qs[0]);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("basic_trgout", TRGOUT, k == 1);
            check("basic_pv", PEAKVALID, k == 4);
            check("basic_busy", BUSY, (k >= 1) && (k <= 13));
            if (k == 1) check("basic_trgcnt", TRGCOUNT, 1);
            if (k == 4) check("basic_peak", TRGPEAK, 40);
            LYCALOQSUM = (k < 4) ? QW'(qs[k]) : '0;
        end
        LYCALOTRG = 1'b0; tick();

        // Negative peak, G=3.
        cfg(2'd0, 0, 3, 0);
        LYCALOTRG = 1'b1; LYCALOQSUM = -20'sd50; tick();
        LYCALOQSUM = -20'sd7; tick();
        LYCALOQSUM = -20'sd20; tick();
        check("neg_pv", PEAKVALID, 1);
        check("neg_peak", TRGPEAK, -7);
        LYCALOTRG = 1'b0; tick();

        // Prescale 2: six isolated edges, accepts on the third and sixth.
        cfg(2'd0, 2, 1, 0); clr_counts();
        for (int e = 0; e < 6; e++) begin
            LYCALOTRG = 1'b1; tick();
            check($sformatf("presc_edge%0d", e + 1), TRGOUT, (e == 2) || (e == 5));
            LYCALOTRG = 1'b0;
            repeat (49) tick();
        end
        check("presc_raw", RAWCOUNT, 6);
        check("presc_trgcnt", TRGCOUNT, 2);

        // Dead time: G=1, H=5, edges at 10, 13, 16.
        cfg(2'd0, 0, 1, 5); clr_counts();
        for (int c = 0; c <= 18; c++) begin
            LYCALOTRG = (c == 10) || (c == 13) || (c == 16);
            tick();
            check($sformatf("dead_trgout@%0d", c + 1), TRGOUT, (c == 10) || (c == 16));
            check($sformatf("dead_busy@%0d", c + 1), BUSY,
                  ((c + 1 >= 11) && (c + 1 <= 15)) || (c + 1 >= 17));
        end
        check("dead_raw", RAWCOUNT, 3);
        check("dead_trgcnt", TRGCOUNT, 2);
        LYCALOTRG = 1'b0; repeat (6) tick();

        // Level held through the window and the holdoff.
        cfg(2'd0, 0, 2, 3);
        cnt = 0;
        LYCALOTRG = 1'b1;
        repeat (20) begin tick(); cnt += int'(TRGOUT); end
        check("level_hold_pulses", cnt, 1);
        LYCALOTRG = 1'b0; repeat (3) tick();

        // AND source: one input alone does nothing.
        cfg(2'd2, 0, 1, 0);
        cnt = 0;
        LYCALOTRG = 1'b1;
        repeat (5) begin tick(); cnt += int'(TRGOUT); end
        check("and_single_pulses", cnt, 0);
        LYCALOORTRG = 1'b1; tick();
        check("and_both_trgout", TRGOUT, 1);
        tick();
        check("and_both_once", TRGOUT, 0);
        LYCALOTRG = 1'b0; LYCALOORTRG = 1'b0; tick();

        // Source high at reset release.
        cfg(2'd0, 0, 1, 0);
        LYCALOTRG = 1'b1; RST = 1'b1; tick(); RST = 1'b0;
        cnt = 0;
        repeat (5) begin tick(); cnt += int'(TRGOUT); end
        check("rst_high_pulses", cnt, 0);
        LYCALOTRG = 1'b0; tick();
        LYCALOTRG = 1'b1; tick();
        check("rst_high_next_edge", TRGOUT, 1);
        LYCALOTRG = 1'b0; tick();

        // Reset during an 8-cycle window, asserted at cycle n+3.
        cfg(2'd0, 0, 8, 4);
        LYCALOTRG = 1'b1; LYCALOQSUM = 20'sd100; tick();
        LYCALOTRG = 1'b0; tick(); tick();
        RST = 1'b1; tick(); RST = 1'b0;
        check("midrst_trgout", TRGOUT, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_pv", PEAKVALID, 0);
        check("midrst_peak", TRGPEAK, 0);
        check("midrst_raw", RAWCOUNT, 0);
        check("midrst_trgcnt", TRGCOUNT, 0);
        cnt = 0;
        repeat (10) begin tick(); cnt += int'(PEAKVALID); end
        check("midrst_no_pv", cnt, 0);
        LYCALOTRG = 1'b1; LYCALOQSUM = 20'sd77; tick();
        check("midrst_next_trgout", TRGOUT, 1);
        check("midrst_next_trgcnt", TRGCOUNT, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("midrst_next_pv", PEAKVALID, k == 8);
        end
        check("midrst_next_peak", TRGPEAK, 77);
        LYCALOTRG = 1'b0; repeat (6) tick();

        // A clear in the same cycle as an edge wins over the count.
        cfg(2'd0, 0, 1, 0);
        LYCALOTRG = 1'b1; CNTCLR = 1'b1; tick();
        CNTCLR = 1'b0;
        check("clr_edge_trgout", TRGOUT, 1);
        check("clr_edge_raw", RAWCOUNT, 0);
        check("clr_edge_trgcnt", TRGCOUNT, 0);
        LYCALOTRG = 1'b0; tick();

        // Saturation of the 3-bit instance.
        clr_counts();
        repeat (10) begin LYCALOTRG = 1'b1; tick(); LYCALOTRG = 1'b0; tick(); end
        check("sat_raw_small", s_raw, 7);
        check("sat_trg_small", s_trg, 7);
        check("sat_raw_main", RAWCOUNT, 10);

        // Randomized segments checked against the event model.
        cyc = 0;
        for (int seg = 0; seg < 8; seg++) begin
            cfg(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 5));
            for (int i = 0; i < 400; i++) begin
                RST         = (i == 0) || ($urandom_range(0, 199) == 0);
                ENABLE      = ($urandom_range(0, 9) != 0);
                CNTCLR      = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 3) == 0) LYCALOTRG = ~LYCALOTRG;
                if ($urandom_range(0, 3) == 0) LYCALOORTRG = ~LYCALOORTRG;
                if ($urandom_range(0, 99) == 0) PRESCALE = 16'($urandom_range(0, 3));
                LYCALOQSUM  = QW'($urandom);
                hist[cyc % 256] = int'(LYCALOQSUM);

                e_trgout = 1'b0;
                if (RST) begin
                    m_sprev = 1'b1; m_pcnt = 0; m_next_free = 0; m_pv_at = -1;
                    m_raw = 0; m_trg = 0; m_sraw = 0; m_strg = 0; m_peak = 0;
                    e_pv = 1'b0; e_busy = 1'b0;
                end else begin
                    s       = src_of(SRCSEL, LYCALOTRG, LYCALOORTRG);
                    cand    = s && !m_sprev && ENABLE;
                    m_sprev = s;
                    acc     = 1'b0;
                    if (cand) begin
                        if (m_raw < 64'hFFFF_FFFF) m_raw++;
                        if (m_sraw < 7) m_sraw++;
                        if (cyc >= m_next_free) begin
                            if (m_pcnt >= int'(PRESCALE)) begin acc = 1'b1; m_pcnt = 0; end
                            else m_pcnt++;
                        end
                    end
                    if (acc) begin
                        if (m_trg < 64'hFFFF_FFFF) m_trg++;
                        if (m_strg < 7) m_strg++;
                        g           = (GATELEN == 0) ? 1 : int'(GATELEN);
                        m_h         = int'(HOLDOFF);
                        m_next_free = cyc + g + m_h;
                        m_pv_at     = cyc + g;
                        m_win_start = cyc;
                    end
                    if (CNTCLR) begin m_raw = 0; m_trg = 0; m_sraw = 0; m_strg = 0; end
                    e_trgout = acc;
                    e_pv     = (m_pv_at == cyc + 1);
                    if (e_pv) begin
                        m_peak = hist[m_win_start % 256];
                        for (int c = m_win_start + 1; c <= cyc; c++)
                            if (hist[c % 256] > m_peak) m_peak = hist[c % 256];
                    end
                    e_busy = (cyc + 1 < m_next_free);
                end

                tick();
                cyc++;
                check("rnd_trgout", TRGOUT, e_trgout);
                check("rnd_pv", PEAKVALID, e_pv);
                check("rnd_busy", BUSY, e_busy);
                check("rnd_peak", TRGPEAK, m_peak);
                check("rnd_raw", RAWCOUNT, m_raw);
                check("rnd_trgcnt", TRGCOUNT, m_trg);
                check("rnd_small_trgout", s_trgout, e_trgout);
                check("rnd_small_pv", s_pv, e_pv);
                check("rnd_small_busy", s_busy, e_busy);
                check("rnd_small_peak", s_trgpeak, m_peak);
                check("rnd_small_raw", s_raw, m_sraw);
                check("rnd_small_trgcnt", s_trg, m_strg);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
